dmem_bridge: RTL and testbench



---
 rtl/common.sv | 7 +
 rtl/lane_align.sv | 21 ++
 rtl/dmem_bridge.sv | 93 +++++++++
 tb/tb_dmem_bridge.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/common.sv
// common: shared types and width codes for the data-side bridge.
package common;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} dmem_state;
  localparam logic [1:0] WSTRB_BYTE = 2'd0;
  localparam logic [1:0] WSTRB_HALF = 2'd1;
  localparam logic [1:0] WSTRB_WORD = 2'd2;
endpackage

// File: rtl/lane_align.sv
// lane_align: byte-lane strobes, store replication, load right-alignment and alignment check.
module lane_align
  import common::*;
(
  input  logic [1:0]  width,
  input  logic [1:0]  offset,
  input  logic [1:0]  rsp_offset,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  strb,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_shift,
  output logic        misaligned
);
  always_comb begin
    strb = width == WSTRB_BYTE ? 4'b0001 << offset : width == WSTRB_HALF ? 4'b0011 << offset : 4'hF;
    wdata_rep = width == WSTRB_BYTE ? {4{wdata[7:0]}} : width == WSTRB_HALF ? {2{wdata[15:0]}} : wdata;
    rdata_shift = rdata >> {rsp_offset, 3'b000};
    misaligned = width == 2'd3 || (width == WSTRB_HALF && offset[0]) || (width == WSTRB_WORD && offset != 2'd0);
  end
endmodule

// File: rtl/dmem_bridge.sv
// dmem_bridge: turns the core's combinational load/store into a registered valid/ready bus transaction.
module dmem_bridge
  import common::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1)
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  input  logic        read_enable,
  input  logic        write_enable,
  input  logic [1:0]  write_wstrb,
  output logic [31:0] read_data,
  output logic        stall,
  output logic        misaligned,
  output logic        bus_error,
  output logic        bus_req_valid,
  input  logic        bus_req_ready,
  output logic [31:0] bus_addr,
  output logic        bus_we,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  input  logic        bus_resp_valid,
  input  logic [31:0] bus_rdata
);
  dmem_state state, state_n;
  logic [CW-1:0] cnt, cnt_inc;
  logic [1:0] offset;
  logic [31:0] rd_reg, wdata_rep, rdata_shift;
  logic [3:0] strb;
  logic mis_a, req, tmo, tmo_hit, launch;

  lane_align u_lane (
    .width      (write_wstrb),
    .offset     (address[1:0]),
    .rsp_offset (offset),
    .wdata      (write_data),
    .rdata      (bus_rdata),
    .strb       (strb),
    .wdata_rep  (wdata_rep),
    .rdata_shift(rdata_shift),
    .misaligned (mis_a)
  );

  // A response arriving in the same WAIT cycle as the timeout still completes normally.
  always_comb begin
    req = read_enable | write_enable;
    cnt_inc = cnt + CW'(1);
    tmo = cnt_inc == CW'(TIMEOUT_CYCLES);
    tmo_hit = (state == REQ && tmo) || (state == WAIT && !bus_resp_valid && tmo);
    launch = state == IDLE && req && !mis_a;
    misaligned = state == IDLE && req && mis_a;
    stall = launch || state == REQ || state == WAIT;
    bus_req_valid = state == REQ;
    read_data = state == DONE ? rd_reg : '0;
    state_n = state;
    case (state)
      IDLE:    state_n = launch ? REQ : IDLE;
      REQ:     state_n = tmo ? DONE : bus_req_ready ? WAIT : REQ;
      WAIT:    state_n = (bus_resp_valid || tmo) ? DONE : WAIT;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      offset <= '0;
      rd_reg <= '0;
      bus_error <= 1'b0;
      bus_addr <= '0;
      bus_we <= 1'b0;
      bus_wdata <= '0;
      bus_wstrb <= '0;
    end else begin
      state <= state_n;
      bus_error <= tmo_hit;
      cnt <= launch ? '0 : (state == REQ || state == WAIT) ? cnt_inc : cnt;
      if (launch) begin
        bus_addr <= {address[31:2], 2'b00};
        bus_we <= write_enable;
        bus_wdata <= wdata_rep;
        bus_wstrb <= strb;
        offset <= address[1:0];
      end
      if (state == WAIT && bus_resp_valid) rd_reg <= bus_we ? '0 : rdata_shift;
      else if (tmo_hit) rd_reg <= '0;
    end
  end
endmodule

// File: tb/tb_dmem_bridge.sv
// tb_dmem_bridge: randomized and directed checks of dmem_bridge against a lane-level reference model.
module tb_dmem_bridge;
  import common::*;
  localparam int T = 8;
  logic clock = 0, reset = 1;
  logic [31:0] address = 0, write_data = 0, bus_rdata = 0;
  logic read_enable = 0, write_enable = 0, bus_req_ready = 0, bus_resp_valid = 0;
  logic [1:0] write_wstrb = 0;
  logic [31:0] read_data, bus_addr, bus_wdata;
  logic stall, misaligned, bus_error, bus_req_valid, bus_we;
  logic [3:0] bus_wstrb;
  int checks = 0, fails = 0;
  int o_stalls, o_errs;
  logic [31:0] o_rd, o_addr, o_wdata;
  logic [3:0] o_wstrb;
  logic o_we, o_seen, o_stable, o_mis0, o_idle;

  always #5 clock = ~clock;

  dmem_bridge #(.TIMEOUT_CYCLES(T)) dut (
    .clock(clock), .reset(reset), .address(address), .write_data(write_data),
    .read_enable(read_enable), .write_enable(write_enable), .write_wstrb(write_wstrb),
    .read_data(read_data), .stall(stall), .misaligned(misaligned), .bus_error(bus_error),
    .bus_req_valid(bus_req_valid), .bus_req_ready(bus_req_ready), .bus_addr(bus_addr),
    .bus_we(bus_we), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
    .bus_resp_valid(bus_resp_valid), .bus_rdata(bus_rdata)
  );

  function automatic int sz(input logic [1:0] w);
    return w == WSTRB_BYTE ? 1 : w == WSTRB_HALF ? 2 : 4;
  endfunction

  function automatic logic [3:0] m_strb(input int off, input int s);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) r[i] = (i >= off && i < off + s);
    return r;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [31:0] wd, input int s);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % s) +: 8];
    return r;
  endfunction

  // Bus-side agent: holds ready low rlo REQ cycles, response low slo WAIT cycles.
  task automatic run_txn(input logic [31:0] a, input logic [31:0] wd, input logic re, input logic we,
                         input logic [1:0] w, input int rlo, input int slo, input logic [31:0] raw);
    int n, rq, wt;
    bit acc;
    n = 0; rq = 0; wt = 0; acc = 0;
    o_stalls = 0; o_errs = 0; o_seen = 0; o_stable = 1;
    o_addr = 0; o_wdata = 0; o_wstrb = 0; o_we = 0;
    @(negedge clock);
    address = a; write_data = wd; read_enable = re; write_enable = we; write_wstrb = w;
    bus_req_ready = 0; bus_resp_valid = 0;
    #1;
    o_mis0 = misaligned;
    while (stall && n < 40) begin
      o_stalls++;
      @(negedge clock);
      bus_req_ready = bus_req_valid && rq >= rlo;
      bus_resp_valid = acc && wt >= slo;
      bus_rdata = bus_resp_valid ? raw : $urandom;
      if (acc) wt++;
      if (bus_req_valid) begin
        if (!o_seen) begin
          o_addr = bus_addr; o_we = bus_we; o_wdata = bus_wdata; o_wstrb = bus_wstrb; o_seen = 1;
        end else if ({bus_addr, bus_we, bus_wdata, bus_wstrb} !== {o_addr, o_we, o_wdata, o_wstrb}) o_stable = 0;
        rq++;
        if (bus_req_ready) acc = 1;
      end
      #1;
      o_errs += int'(bus_error);
      n++;
    end
    o_rd = read_data;
    @(negedge clock);
    read_enable = 0; write_enable = 0; bus_req_ready = 0; bus_resp_valid = 0;
    #1;
    o_errs += int'(bus_error);
    o_idle = !stall && !bus_req_valid && read_data == 0;
  endtask

  task automatic test_reset;
    reset = 1;
    repeat (2) @(negedge clock);
    reset = 0;
    #1;
    checks++;
    if ({read_data, stall, misaligned, bus_error, bus_req_valid, bus_addr, bus_we, bus_wdata, bus_wstrb} !== '0) begin
      fails++; $display("FAIL reset_outputs: got rd=%h st=%b mis=%b err=%b v=%b a=%h we=%b wd=%h sb=%h, want all 0",
        read_data, stall, misaligned, bus_error, bus_req_valid, bus_addr, bus_we, bus_wdata, bus_wstrb);
    end
  endtask

  task automatic test_word_load;
    run_txn(32'h100, $urandom, 1, 0, WSTRB_WORD, 0, 0, 32'hDEADBEEF);
    checks++; if (o_stalls != 3) begin fails++; $display("FAIL word_stall: got %0d want 3", o_stalls); end
    checks++; if (o_rd !== 32'hDEADBEEF) begin fails++; $display("FAIL word_rdata: got %h want deadbeef", o_rd); end
    checks++; if (o_addr !== 32'h100) begin fails++; $display("FAIL word_addr: got %h want 00000100", o_addr); end
    checks++; if (o_wstrb !== 4'hF) begin fails++; $display("FAIL word_wstrb: got %h want f", o_wstrb); end
    checks++; if (o_we !== 1'b0) begin fails++; $display("FAIL word_we: got %b want 0", o_we); end
    checks++; if (o_errs != 0 || !o_idle) begin fails++; $display("FAIL word_end: errs %0d idle %b want 0/1", o_errs, o_idle); end
  endtask

  task automatic test_byte_store_load;
    run_txn(32'h203, 32'h000000A5, 0, 1, WSTRB_BYTE, 0, 0, 32'hFFFFFFFF);
    checks++; if (o_addr !== 32'h200) begin fails++; $display("FAIL bstore_addr: got %h want 00000200", o_addr); end
    checks++; if (o_wstrb !== 4'b1000) begin fails++; $display("FAIL bstore_wstrb: got %b want 1000", o_wstrb); end
    checks++; if (o_wdata !== 32'hA5A5A5A5) begin fails++; $display("FAIL bstore_wdata: got %h want a5a5a5a5", o_wdata); end
    checks++; if (o_we !== 1'b1) begin fails++; $display("FAIL bstore_we: got %b want 1", o_we); end
    checks++; if (o_rd !== 32'h0) begin fails++; $display("FAIL bstore_rd: got %h want 0", o_rd); end
    run_txn(32'h203, 0, 1, 0, WSTRB_BYTE, 0, 0, 32'h7F000000);
    checks++; if (o_rd !== 32'h7F) begin fails++; $display("FAIL bload_rd: got %h want 0000007f", o_rd); end
  endtask

  task automatic test_half_ready_low;
    run_txn(32'h102, 0, 1, 0, WSTRB_HALF, 4, 0, 32'h12345678);
    checks++; if (!o_stable) begin fails++; $display("FAIL half_stable: payload changed while waiting for ready"); end
    checks++; if (o_stalls != 7) begin fails++; $display("FAIL half_stall: got %0d want 7", o_stalls); end
    checks++; if (o_rd !== 32'h1234) begin fails++; $display("FAIL half_rd: got %h want 00001234", o_rd); end
    checks++; if (o_wstrb !== 4'b1100) begin fails++; $display("FAIL half_wstrb: got %b want 1100", o_wstrb); end
  endtask

  task automatic test_misaligned;
    logic [31:0] addrs [4] = '{32'h101, 32'h3, 32'h0, 32'h206};
    logic [1:0] ws [4] = '{WSTRB_WORD, WSTRB_HALF, 2'd3, WSTRB_WORD};
    for (int i = 0; i < 4; i++) begin
      run_txn(addrs[i], $urandom, i != 3, i == 3, ws[i], 0, 0, 0);
      checks++;
      if (o_mis0 !== 1'b1 || o_stalls != 0 || o_seen) begin
        fails++; $display("FAIL misaligned_%0d: mis %b stalls %0d bus_seen %b, want 1/0/0", i, o_mis0, o_stalls, o_seen);
      end
    end
  endtask

  task automatic test_timeout;
    run_txn(32'h40, 0, 1, 0, WSTRB_WORD, 0, 1000, 32'h55555555);
    checks++; if (o_stalls != T + 1) begin fails++; $display("FAIL timeout_stall: got %0d want %0d", o_stalls, T + 1); end
    checks++; if (o_errs != 1) begin fails++; $display("FAIL timeout_error_pulses: got %0d want 1", o_errs); end
    checks++; if (o_rd !== 32'h0 || !o_idle) begin fails++; $display("FAIL timeout_done: rd %h idle %b want 0/1", o_rd, o_idle); end
  endtask

  task automatic test_reset_mid;
    @(negedge clock);
    address = 32'h300; read_enable = 1; write_enable = 0; write_wstrb = WSTRB_WORD;
    @(negedge clock);
    bus_req_ready = 1;
    #1;
    checks++; if (bus_req_valid !== 1'b1) begin fails++; $display("FAIL rmid_req: valid %b want 1", bus_req_valid); end
    @(negedge clock);
    bus_req_ready = 0;
    #1;
    checks++; if (stall !== 1'b1 || bus_req_valid !== 1'b0) begin fails++; $display("FAIL rmid_wait: stall %b valid %b want 1/0", stall, bus_req_valid); end
    reset = 1;
    @(negedge clock);
    reset = 0; read_enable = 0; bus_resp_valid = 1; bus_rdata = 32'hCAFEF00D;
    #1;
    checks++;
    if ({read_data, stall, misaligned, bus_error, bus_req_valid, bus_addr, bus_we, bus_wdata, bus_wstrb} !== '0) begin
      fails++; $display("FAIL rmid_outputs: rd=%h st=%b v=%b a=%h sb=%h want all 0", read_data, stall, bus_req_valid, bus_addr, bus_wstrb);
    end
    @(negedge clock);
    bus_resp_valid = 0;
    #1;
    checks++; if (read_data !== 0 || stall !== 0 || bus_req_valid !== 0) begin fails++; $display("FAIL rmid_ignored: rd %h st %b v %b want 0", read_data, stall, bus_req_valid); end
    run_txn(32'h304, 0, 1, 0, WSTRB_WORD, 0, 0, 32'h0BADC0DE);
    checks++; if (o_stalls != 3 || o_rd !== 32'h0BADC0DE) begin fails++; $display("FAIL rmid_fresh: stalls %0d rd %h want 3/0badc0de", o_stalls, o_rd); end
  endtask

  task automatic test_random;
    for (int k = 0; k < 24; k++) begin
      logic [1:0] w;
      int s, off, op, rlo, slo;
      logic [31:0] a, wd, raw;
      w = 2'($urandom_range(0, 2));
      s = sz(w);
      off = s * $urandom_range(0, 4 / s - 1);
      a = {$urandom, 2'b00} | 32'(off);
      wd = $urandom; raw = $urandom;
      op = $urandom_range(0, 2);
      rlo = $urandom_range(0, 2); slo = $urandom_range(0, 2);
      run_txn(a, wd, op != 1, op != 0, w, rlo, slo, raw);
      checks++;
      if (o_mis0 !== 0 || o_stalls != 3 + rlo + slo || o_errs != 0 || !o_stable || !o_idle) begin
        fails++; $display("FAIL rand_%0d_flow: mis %b stalls %0d (want %0d) errs %0d stable %b idle %b", k, o_mis0, o_stalls, 3 + rlo + slo, o_errs, o_stable, o_idle);
      end
      checks++;
      if (o_addr !== {a[31:2], 2'b00} || o_we !== (op != 0) || o_wstrb !== m_strb(off, s)) begin
        fails++; $display("FAIL rand_%0d_req: a %h we %b sb %b want %h %b %b", k, o_addr, o_we, o_wstrb, {a[31:2], 2'b00}, op != 0, m_strb(off, s));
      end
      checks++;
      if (o_wdata !== m_wdata(wd, s)) begin fails++; $display("FAIL rand_%0d_wdata: got %h want %h", k, o_wdata, m_wdata(wd, s)); end
      checks++;
      if (o_rd !== (op != 0 ? 32'h0 : raw >> (8 * off))) begin
        fails++; $display("FAIL rand_%0d_rdata: got %h want %h", k, o_rd, op != 0 ? 32'h0 : raw >> (8 * off));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_word_load;
    test_byte_store_load;
    test_half_ready_low;
    test_misaligned;
    test_timeout;
    test_reset_mid;
    test_random;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
